// File: rtl/logic_gates_pkg.sv
// logic_gates_pkg: shared constants and types for the gate-level logic library.
package logic_gates_pkg;
    localparam int LOW_CNT_W_DEFAULT = 16;
    typedef logic [LOW_CNT_W_DEFAULT-1:0] low_cnt_t;
endpackage

// File: rtl/nand4_core.sv
// nand4_core: purely combinational four-input NAND.
module nand4_core (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic y
);
    assign y = ~(a & b & c & d);
endmodule

// File: rtl/four_input_nand_gate.sv
// four_input_nand_gate: combinational NAND4 plus a registered copy and a
// saturating count of clock cycles in which the NAND output was low.
module four_input_nand_gate
    import logic_gates_pkg::*;
#(
    parameter int CNT_W = $bits(low_cnt_t)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             clr,
    output logic             e,
    output logic             e_q,
    output logic [CNT_W-1:0] low_cnt
);
    logic             w_e;
    logic             r_e_q;
    logic [CNT_W-1:0] r_low_cnt;
    nand4_core u_core (
        .a(a),
        .b(b),
        .c(c),
        .d(d),
        .y(w_e)
    );
    // clr wins over increment; the count sticks at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e_q     <= 1'b1;
            r_low_cnt <= '0;
        end else begin
            r_e_q <= w_e;
            if (clr)
                r_low_cnt <= '0;
            else if (!w_e && r_low_cnt != '1)
                r_low_cnt <= r_low_cnt + CNT_W'(1);
        end
    end
    assign e       = w_e;
    assign e_q     = r_e_q;
    assign low_cnt = r_low_cnt;
endmodule

// File: tb/tb_four_input_nand_gate.sv
// tb_four_input_nand_gate: random and directed stimulus with a queue-based
// scoreboard checked against an arithmetic reference model.
module tb_four_input_nand_gate;
    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;
    typedef struct packed {
        logic          e;
        logic          eq;
        logic [CW-1:0] cnt;
    } exp_t;
    logic          clk = 0, rst = 0, a = 0, b = 0, c = 0, d = 0, clr = 0;
    logic          e, e_q;
    logic [CW-1:0] low_cnt;
    bit            clk_en = 0;
    exp_t          sb[$];
    event          chk;
    int            n_cmp = 0, n_bad = 0;
    int            m_cnt = 0;
    bit            m_eq = 1;
    logic [15:0]   cover_seen = '0;
    four_input_nand_gate #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .clr(clr), .e(e), .e_q(e_q), .low_cnt(low_cnt)
    );
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end
    function automatic bit nand_ref(input logic [3:0] v);
        return $countones(v) != 4;
    endfunction
    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d at %0t", nm, act, req, $time);
        end
    endtask
    // Monitor: samples the DUT shortly after each stimulus notification.
    initial forever begin
        exp_t x;
        @(chk);
        #1;
        if (sb.size() == 0) check("sb_underflow", 1, 0);
        else begin
            x = sb.pop_front();
            check("e", int'(e), int'(x.e));
            check("e_q", int'(e_q), int'(x.eq));
            check("low_cnt", int'(low_cnt), int'(x.cnt));
        end
    end
    task automatic expect_now();
        exp_t x;
        x.e   = nand_ref({a, b, c, d});
        x.eq  = m_eq;
        x.cnt = CW'(m_cnt);
        sb.push_back(x);
        ->chk;
        #2;
    endtask
    task automatic step(input logic [3:0] v, input bit cl);
        @(posedge clk);
        if (!rst) begin
            m_eq  = nand_ref({a, b, c, d});
            m_cnt = clr ? 0 : (!m_eq && m_cnt < MAX) ? m_cnt + 1 : m_cnt;
        end
        #2;
        {a, b, c, d} = v;
        clr = cl;
        expect_now();
    endtask
    initial begin
        {a, b, c, d} = 4'hF;
        #1 rst = 1;
        #1 expect_now();
        #5 expect_now();
        rst = 0;
        #3;
        for (int t = 0; t < 140; t++) begin
            a = 1'((t / 10) % 2);
            b = 1'((t / 7) % 2);
            c = 1'((t / 5) % 2);
            d = 1'(t % 2);
            cover_seen[{a, b, c, d}] = 1'b1;
            expect_now();
            #8;
        end
        check("sweep_coverage", int'(cover_seen), 16'hFFFF);
        {a, b, c, d} = 4'h0;
        clk_en = 1;
        repeat (3) step(4'hF, 0);
        step(4'h7, 0);
        step(4'h0, 0);
        step(4'h0, 0);
        check("reg_path_cnt", int'(low_cnt), 3);
        repeat (20) step(4'hF, 0);
        check("saturated_cnt", int'(low_cnt), MAX);
        step(4'hF, 1);
        step(4'hF, 0);
        step(4'hF, 0);
        step(4'h0, 1);
        repeat (6) step(4'hF, 0);
        check("pre_reset_cnt", int'(low_cnt), 5);
        #2 rst = 1;
        m_eq  = 1;
        m_cnt = 0;
        expect_now();
        @(negedge clk) rst = 0;
        step(4'hF, 0);
        step(4'hF, 0);
        repeat (200) step(4'($urandom_range(0, 15) | ($urandom_range(0, 1) ? 4'hF : 4'h0)),
                          $urandom_range(0, 15) == 0);
        #20;
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
